mib_slave: RTL and testbench
============================

// Module: mib_slave
//
// PURPOSE
// - Responder end of the MIB bus: decodes MIB address/data phases from mib_master and issues one local
//   intf_cmd-style transaction per MIB access to this FPGA's register fabric.
// - Returns MIB_ACK for writes and drives read data back onto the shared 16-bit MIB_AD bus.
// - Sits at the top level of each slave FPGA, behind the MIB pin registers; the top level owns the tri-state.
//
// PARAMETERS
// - P_MIB_MSN                4'h6  address MSN (byte_addr[23:20]) this slave answers to
// - P_CMD_ACK_TIMEOUT_CLKS   16    clocks to wait for i_cmd_ack before abandoning the local transaction
//
// PORTS
// - i_sysclk          in   1    MIB/cmd clock (25 MHz); the only clock
// - i_rst_n           in   1    reset, asynchronous assert, active-low
// - i_mib_start       in   1    master start; high exactly during address phase 1
// - i_mib_rd_wr_n     in   1    1=read 0=write; sampled with i_mib_start
// - i_mib_ad          in   16   MIB AD bus as seen at slave input register
// - o_mib_ack         out  1    write-complete / read-data-valid strobe to master
// - o_mib_ad_oe       out  1    1=top level drives o_mib_ad onto MIB_AD; 0=high-Z
// - o_mib_ad          out  16   read data halves
// - o_cmd_sel         out  1    one-clock local command strobe
// - o_cmd_rd_wr_n     out  1    local direction
// - o_cmd_byte_addr   out  20   byte_addr[19:0] of the MIB access
// - o_cmd_wdata       out  32   local write data
// - i_cmd_ack         in   1    local completion; rdata valid same clock
// - i_cmd_rdata       in   32   local read data
// - o_cmd_timeout     out  1    one-clock pulse when local ack never arrives
//
// BEHAVIOUR
// - All outputs registered. Reset values: all 0; state IDLE.
// - Phases at i_mib_*, clock T = start:
//   - T: A1, AD[3:0]=addr[19:16], AD[7:4]=addr[23:20] MSN
//   - T+1: A2, AD=addr[15:0]
//   - write only: T+2 = D1 (AD = wdata[31:16]), T+3 = D2 (AD = wdata[15:0])
// - FSM states: IDLE, ADDR2, WDATA1, WDATA2, CMD_WAIT, WACK, RDATA1, RDATA2.
// - IDLE
//   - Start with MSN==P_MIB_MSN -> ADDR2; capture rd_wr_n and addr[19:16].
//   - MSN mismatch -> stay IDLE; no outputs change.
// - ADDR2
//   - Capture addr[15:0].
//   - Write -> WDATA1.
//   - Read -> CMD_WAIT with o_cmd_sel=1 at T+2.
// - Write data
//   - WDATA1 -> WDATA2; capture the upper half.
//   - WDATA2 captures the lower half -> CMD_WAIT, o_cmd_sel=1 at T+4.
// - CMD_WAIT
//   - o_cmd_sel is high for exactly one clock; addr, rd_wr_n and wdata are held stable until exit.
//   - Timeout counter starts at 0 on entry; exit is decided on the clock the counter reaches P_CMD_ACK_TIMEOUT_CLKS.
//   - On i_cmd_ack:
//     - write -> WACK, o_mib_ack=1 for one clock, then IDLE.
//     - read -> latch rdata and go to RDATA1.
//   - Timeout -> o_cmd_timeout=1 for one clock; then see CONFIGURATION.
// - Read return
//   - RDATA1: o_mib_ad_oe=1, o_mib_ad=rdata[31:16], o_mib_ack=1.
//   - RDATA2: o_mib_ad=rdata[15:0], o_mib_ack=1.
//   - Next clock: oe=0, ack=0 -> IDLE.
// - i_cmd_ack in any state other than CMD_WAIT is ignored.
// - i_mib_start outside IDLE is ignored (master is single-outstanding).
// - Async reset mid-transaction:
//   - o_mib_ad_oe and o_mib_ack drop immediately; o_cmd_sel drops immediately.
//   - No local command is issued after release unless a new start arrives.
// - Back-to-back: a start on the clock after WACK/RDATA2 returns to IDLE is accepted.
//
// CONFIGURATION
// - MIB_SLAVE_TIMEOUT_RESP_EN defined: on local timeout the slave still completes the MIB access:
//   - write -> one o_mib_ack pulse.
//   - read -> returns 32'hDEAD_BEEF via RDATA1/RDATA2.
// - Not defined: on local timeout -> IDLE, no o_mib_ack, oe stays 0; the master's own MIB timeout reports the failure.
//
// TESTING
// - Write 0x600004=0x01010202
//   -> o_cmd_sel at T+4, byte_addr=0x00004, wdata=0x01010202, rd_wr_n=0.
//   -> local ack at T+6 gives o_mib_ack at T+7.
// - Read 0x600008, local ack 3 clocks after sel with rdata=0x12345678
//   -> oe=1 for 2 clocks; AD=0x1234 then 0x5678, ack high both clocks.
// - Write 0x700000 (MSN mismatch) -> no o_cmd_sel, no ack, oe never asserted.
// - Read 0x600000 with no local ack
//   -> o_cmd_timeout pulses 16 clocks after sel.
//   -> with _EN: data 0xDEAD/0xBEEF + ack. Without: no ack, IDLE.
// - Assert i_rst_n=0 during RDATA1 -> oe/ack 0 same clock.
//   -> after release, a new read 0x600004 completes normally.
// - Back-to-back write then read with start the clock after WACK -> both complete, correct data.

Source files
------------

// File: rtl/mib_slave_if.sv
// mib_slave_if: MIB bus signals between mib_master and mib_slave as seen at the slave pin registers.
interface mib_slave_if;
  logic        i_mib_start;
  logic        i_mib_rd_wr_n;
  logic [15:0] i_mib_ad;
  logic        o_mib_ack;
  logic        o_mib_ad_oe;
  logic [15:0] o_mib_ad;
  modport master (
    output i_mib_start, i_mib_rd_wr_n, i_mib_ad,
    input  o_mib_ack, o_mib_ad_oe, o_mib_ad
  );
  modport slave (
    input  i_mib_start, i_mib_rd_wr_n, i_mib_ad,
    output o_mib_ack, o_mib_ad_oe, o_mib_ad
  );
endinterface

// File: rtl/mib_slave.sv
// mib_slave: MIB responder issuing one local command per access; defining MIB_SLAVE_TIMEOUT_RESP_EN
// makes a timed-out access still complete on MIB (write ack, read data 32'hDEAD_BEEF).
module mib_slave #(
  parameter logic [3:0] P_MIB_MSN              = 4'h6,
  parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_rst_n,
  mib_slave_if.slave  mib,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [19:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic        i_cmd_ack,
  input  logic [31:0] i_cmd_rdata,
  output logic        o_cmd_timeout
);
`ifdef MIB_SLAVE_TIMEOUT_RESP_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif
  localparam int CW = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, ADDR2, WDATA1, WDATA2, CMD_WAIT, WACK, RDATA1, RDATA2} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lo_q;
  logic [31:0]   rsp;
  logic          tmo;
  assign cnt_d = cnt_q + 1'b1;
  assign tmo   = cnt_d == CW'(P_CMD_ACK_TIMEOUT_CLKS);
  assign rsp   = i_cmd_ack ? i_cmd_rdata : 32'hDEAD_BEEF;
  always_ff @(posedge i_sysclk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      lo_q            <= '0;
      mib.o_mib_ack   <= 1'b0;
      mib.o_mib_ad_oe <= 1'b0;
      mib.o_mib_ad    <= '0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b0;
      o_cmd_byte_addr <= '0;
      o_cmd_wdata     <= '0;
      o_cmd_timeout   <= 1'b0;
    end else begin
      o_cmd_sel     <= 1'b0;
      o_cmd_timeout <= 1'b0;
      mib.o_mib_ack <= 1'b0;
      case (state_q)
        IDLE:
          if (mib.i_mib_start && mib.i_mib_ad[7:4] == P_MIB_MSN) begin
            o_cmd_rd_wr_n          <= mib.i_mib_rd_wr_n;
            o_cmd_byte_addr[19:16] <= mib.i_mib_ad[3:0];
            state_q                <= ADDR2;
          end
        ADDR2: begin
          o_cmd_byte_addr[15:0] <= mib.i_mib_ad;
          cnt_q                 <= '0;
          o_cmd_sel             <= o_cmd_rd_wr_n;
          state_q               <= o_cmd_rd_wr_n ? CMD_WAIT : WDATA1;
        end
        WDATA1: begin
          o_cmd_wdata[31:16] <= mib.i_mib_ad;
          state_q            <= WDATA2;
        end
        WDATA2: begin
          o_cmd_wdata[15:0] <= mib.i_mib_ad;
          cnt_q             <= '0;
          o_cmd_sel         <= 1'b1;
          state_q           <= CMD_WAIT;
        end
        CMD_WAIT: begin
          cnt_q         <= cnt_d;
          o_cmd_timeout <= !i_cmd_ack && tmo;
          // a real ack always wins over a timeout landing on the same clock
          if (i_cmd_ack || (tmo && RESP_EN)) begin
            mib.o_mib_ack   <= 1'b1;
            mib.o_mib_ad_oe <= o_cmd_rd_wr_n;
            if (o_cmd_rd_wr_n) mib.o_mib_ad <= rsp[31:16];
            lo_q            <= rsp[15:0];
            state_q         <= o_cmd_rd_wr_n ? RDATA1 : WACK;
          end else if (tmo) state_q <= IDLE;
        end
        WACK: state_q <= IDLE;
        RDATA1: begin
          mib.o_mib_ack <= 1'b1;
          mib.o_mib_ad  <= lo_q;
          state_q       <= RDATA2;
        end
        RDATA2: begin
          mib.o_mib_ad_oe <= 1'b0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mib_slave.sv
// tb_mib_slave: vector table plus scoreboard queues for local commands, MIB responses and timeouts,
// followed by hand sequences for cycle timing, back-to-back starts and mid-read reset.
module tb_mib_slave;
`ifdef MIB_SLAVE_TIMEOUT_RESP_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif
  typedef struct {bit rd; logic [23:0] addr; logic [31:0] wdata; int dly; logic [31:0] rdata;} vec_t;
  typedef struct {bit rd; logic [19:0] addr; logic [31:0] wdata;} cmd_t;
  typedef struct {bit oe; logic [15:0] ad;} resp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_cmd_sel, o_cmd_rd_wr_n, o_cmd_timeout;
  logic [19:0] o_cmd_byte_addr;
  logic [31:0] o_cmd_wdata;
  logic        i_cmd_ack = 1'b0;
  logic [31:0] i_cmd_rdata = 32'h0;
  int          checks = 0, failures = 0;
  int          cyc = 0, t0 = 0, sel_cyc = 0, ack_cyc = 0, tmo_cyc = 0;
  int          tmo_exp = 0, tmo_seen = 0, oe_glitch = 0;
  int          ack_dly = 0, cd = 0;
  logic [31:0] ack_rdata = 32'h0, rd_hold = 32'h0;
  logic        ack_prev = 1'b0;
  cmd_t        cmd_q[$];
  resp_t       resp_q[$];
  cmd_t        c;
  resp_t       r;
  vec_t        vecs[9];
  mib_slave_if mib();
  mib_slave dut (
    .i_sysclk(clk), .i_rst_n(rst_n), .mib(mib),
    .o_cmd_sel(o_cmd_sel), .o_cmd_rd_wr_n(o_cmd_rd_wr_n), .o_cmd_byte_addr(o_cmd_byte_addr),
    .o_cmd_wdata(o_cmd_wdata), .i_cmd_ack(i_cmd_ack), .i_cmd_rdata(i_cmd_rdata),
    .o_cmd_timeout(o_cmd_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  // local register fabric: ack ack_dly clocks after the sel it saw
  always @(negedge clk) begin
    i_cmd_ack = 1'b0;
    i_cmd_rdata = $urandom;
    if (!rst_n) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_cmd_ack = 1'b1;
        i_cmd_rdata = rd_hold;
      end
    end
    if (rst_n && o_cmd_sel && ack_dly > 0) begin
      cd = ack_dly;
      rd_hold = ack_rdata;
    end
  end
  always @(negedge clk)
    if (!rst_n) ack_prev = 1'b0;
    else begin
      if (o_cmd_sel) begin
        sel_cyc = cyc;
        if (cmd_q.size() == 0) check("sel_unexpected", 1, 0);
        else begin
          c = cmd_q.pop_front();
          check("cmd_rd_wr_n", o_cmd_rd_wr_n, c.rd);
          check("cmd_addr", o_cmd_byte_addr, c.addr);
          if (!c.rd) check("cmd_wdata", o_cmd_wdata, c.wdata);
        end
      end
      if (mib.o_mib_ack) begin
        if (!ack_prev) ack_cyc = cyc;
        if (resp_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          r = resp_q.pop_front();
          check("ad_oe", mib.o_mib_ad_oe, r.oe);
          if (r.oe) check("ad_data", mib.o_mib_ad, r.ad);
        end
      end
      if (mib.o_mib_ad_oe && !mib.o_mib_ack) oe_glitch++;
      if (o_cmd_timeout) begin
        tmo_cyc = cyc;
        tmo_seen++;
      end
      ack_prev = mib.o_mib_ack;
    end
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  // drives the MIB phases from a negedge and queues what the slave must produce
  task automatic xfer(bit rd, logic [23:0] a, logic [31:0] wd, int dly, logic [31:0] rdat);
    bit hit = a[23:20] == 4'h6;
    bit ok = dly >= 1 && dly <= 15;
    logic [31:0] d = ok ? rdat : 32'hDEAD_BEEF;
    ack_dly = dly;
    ack_rdata = rdat;
    if (hit) cmd_q.push_back('{rd, a[19:0], wd});
    if (hit && (ok || RESP_EN)) begin
      if (rd) begin
        resp_q.push_back('{1'b1, d[31:16]});
        resp_q.push_back('{1'b1, d[15:0]});
      end else resp_q.push_back('{1'b0, 16'h0});
    end
    if (hit && !ok) tmo_exp++;
    t0 = cyc;
    mib.i_mib_start = 1'b1;
    mib.i_mib_rd_wr_n = rd;
    mib.i_mib_ad = {8'h00, a[23:20], a[19:16]};
    @(negedge clk);
    mib.i_mib_start = 1'b0;
    mib.i_mib_ad = a[15:0];
    if (!rd) begin
      @(negedge clk);
      mib.i_mib_ad = wd[31:16];
      @(negedge clk);
      mib.i_mib_ad = wd[15:0];
    end
    @(negedge clk);
    mib.i_mib_ad = 16'h0;
  endtask
  initial begin
    vecs[0] = '{1'b0, 24'h600004, 32'h0101_0202, 2, 32'h0};
    vecs[1] = '{1'b1, 24'h600008, 32'h0, 3, 32'h1234_5678};
    vecs[2] = '{1'b0, 24'h700000, 32'h5555_AAAA, 2, 32'h0};
    vecs[3] = '{1'b1, 24'h600000, 32'h0, -1, 32'h0};
    vecs[4] = '{1'b0, 24'h6ABCDE, 32'hA5A5_5A5A, 15, 32'h0};
    vecs[5] = '{1'b1, 24'h6FFFFE, 32'h0, 1, 32'hFFFF_0000};
    vecs[6] = '{1'b0, 24'h600010, 32'h1357_9BDF, -1, 32'h0};
    vecs[7] = '{1'b1, 24'h512340, 32'h0, 2, 32'h0BAD_0BAD};
    vecs[8] = '{1'b1, 24'h600020, 32'h0, 16, 32'h7777_8888};
    mib.i_mib_start = 1'b0;
    mib.i_mib_rd_wr_n = 1'b0;
    mib.i_mib_ad = 16'h0;
    idle(3);
    check("rst_ctl", {mib.o_mib_ack, mib.o_mib_ad_oe, o_cmd_sel, o_cmd_rd_wr_n, o_cmd_timeout, mib.o_mib_ad}, 0);
    check("rst_addr", o_cmd_byte_addr, 0);
    check("rst_wdata", o_cmd_wdata, 0);
    rst_n = 1'b1;
    idle(2);
    foreach (vecs[i]) begin
      xfer(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].rdata);
      idle((vecs[i].dly < 1 || vecs[i].dly > 15) ? 24 : vecs[i].dly + 8);
    end
    xfer(1'b0, 24'h600004, 32'h0101_0202, 2, 32'h0);
    idle(8);
    check("wr_sel_cycle", sel_cyc - t0, 4);
    check("wr_ack_cycle", ack_cyc - t0, 7);
    xfer(1'b1, 24'h600008, 32'h0, 3, 32'h1234_5678);
    idle(10);
    check("rd_sel_cycle", sel_cyc - t0, 2);
    check("rd_ack_cycle", ack_cyc - sel_cyc, 4);
    xfer(1'b1, 24'h600000, 32'h0, -1, 32'h0);
    idle(24);
    check("timeout_cycle", tmo_cyc - sel_cyc, 16);
    xfer(1'b0, 24'h600014, 32'hCAFE_0001, 2, 32'h0);
    idle(4);
    xfer(1'b1, 24'h60000C, 32'h0, 2, 32'hA1B2_C3D4);
    idle(8);
    check("b2b_rd_sel_cycle", sel_cyc - t0, 2);
    xfer(1'b1, 24'h600008, 32'h0, 3, 32'h1234_5678);
    for (int i = 0; i < 20 && !mib.o_mib_ad_oe; i++) @(negedge clk);
    check("rdata1_reached", mib.o_mib_ad_oe, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_oe", mib.o_mib_ad_oe, 0);
    check("rst_mid_ack", mib.o_mib_ack, 0);
    check("rst_mid_sel", o_cmd_sel, 0);
    resp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(6);
    xfer(1'b1, 24'h600004, 32'h0, 2, 32'hCAFE_F00D);
    idle(10);
    check("timeout_count", tmo_seen, tmo_exp);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    check("oe_without_ack", oe_glitch, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
